wb_regfile: RTL

Consumer end of the MEM/WB pipeline interface: the writeback stage fused with the 32x32 architectural register file.
- Selects writeback data from the MEM/WB outputs (load data, ALU result or link address).
- Commits that data to the register file on the clock edge.
- Serves two combinational ID-stage read ports with write-first bypass.
- Keeps a retired-write counter for debug and performance.

---
 rtl/mips_pkg.sv | 14 +
 rtl/wb_mux.sv | 29 ++
 rtl/wb_regfile.sv | 88 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the writeback source encoding.
package mips_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;
  localparam int unsigned DATA_W  = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_mux.sv
// Writeback data select: link address beats load data, which beats the ALU result.
module wb_mux
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] LoadMux,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] PCPlus4,
  input  logic              MemtoReg,
  input  logic              WriteDataSel,
  output logic [DATA_W-1:0] WriteData
);

  wb_src_e src;

  // Resolve the source by priority, then steer the chosen operand.
  always_comb begin
    src = WB_ALU;
    if (WriteDataSel) src = WB_LINK;
    else if (MemtoReg) src = WB_LOAD;

    WriteData = ALUResult;
    unique case (src)
      WB_LINK: WriteData = PCPlus4;
      WB_LOAD: WriteData = LoadMux;
      default: WriteData = ALUResult;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage fused with the architectural register file: write-first
// bypassed read ports and a retired-write counter.
module wb_regfile
  import mips_pkg::REG_ZERO;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [DATA_W-1:0]           MEM_WB_LoadMux,
  input  logic [DATA_W-1:0]           MEM_WB_ALUResult,
  input  logic [DATA_W-1:0]           MEM_WB_PCPlus4,
  input  logic [$clog2(NUM_REGS)-1:0] MEM_WB_RegDst,
  input  logic                        MEM_WB_RegWrite,
  input  logic                        MEM_WB_MemtoReg,
  input  logic                        MEM_WB_WriteDataSel,
  input  logic                        MEM_WB_WriteEnable,
  input  logic [$clog2(NUM_REGS)-1:0] ReadRegister1,
  input  logic [$clog2(NUM_REGS)-1:0] ReadRegister2,
  output logic [DATA_W-1:0]           ReadData1,
  output logic [DATA_W-1:0]           ReadData2,
  output logic [DATA_W-1:0]           WB_WriteData,
  output logic                        WB_Commit,
  output logic [CNT_W-1:0]            RetireCount
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // The memory write enable travels with the pipe but has no meaning here.
  logic unused_wen;
  assign unused_wen = MEM_WB_WriteEnable;

  wb_mux u_wb_mux (
    .LoadMux      (MEM_WB_LoadMux),
    .ALUResult    (MEM_WB_ALUResult),
    .PCPlus4      (MEM_WB_PCPlus4),
    .MemtoReg     (MEM_WB_MemtoReg),
    .WriteDataSel (MEM_WB_WriteDataSel),
    .WriteData    (WB_WriteData)
  );

  // A write commits only to a nonzero register and never during reset.
  always_comb begin
    WB_Commit = MEM_WB_RegWrite && (MEM_WB_RegDst != REG_ZERO) && !Rst;
  end

  // Next-state for storage and counter; reset clears everything.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    cnt_d = cnt_q;
    if (WB_Commit) begin
      regs_d[MEM_WB_RegDst] = WB_WriteData;
      cnt_d                 = cnt_q + CNT_W'(1);
    end
    if (Rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
      cnt_d = '0;
    end
  end

  // Storage and counter registers.
  always_ff @(posedge Clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    cnt_q <= cnt_d;
  end

  assign RetireCount = cnt_q;

  // Read port 1: zero register, then same-cycle bypass, then storage.
  always_comb begin
    ReadData1 = regs_q[ReadRegister1];
    if (ReadRegister1 == REG_ZERO) ReadData1 = '0;
    else if (WB_Commit && (ReadRegister1 == MEM_WB_RegDst)) ReadData1 = WB_WriteData;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    ReadData2 = regs_q[ReadRegister2];
    if (ReadRegister2 == REG_ZERO) ReadData2 = '0;
    else if (WB_Commit && (ReadRegister2 == MEM_WB_RegDst)) ReadData2 = WB_WriteData;
  end

endmodule
